// File: rtl/amstrad_asic_unlock.sv
// CPC Plus ASIC unlock-sequence detector snooping CRTC-select I/O writes.
// Optional debug outputs (state, index, unlock counter) when UNLOCK_DEBUG_EN is defined.
module amstrad_asic_unlock #(
  parameter int unsigned FULL_DECODE = 0,
  parameter logic [7:0]  UNLOCK_BYTE = 8'hEE
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic        io_WR,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  output logic        asic_unlocked,
  output logic        unlock_pulse,
  output logic        lock_pulse
`ifdef UNLOCK_DEBUG_EN
  ,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_idx,
  output logic [7:0]  dbg_unlock_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    MATCH = 2'd2,
    FINAL = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       old_wr_q, old_wr_d;
  logic       unlocked_q, unlocked_d;
  logic       unlock_pulse_q, unlock_pulse_d;
  logic       lock_pulse_q, lock_pulse_d;
  logic       port_hit;
  logic       wr_event;
  logic       unused_addr_bits;

  function automatic logic [7:0] seq_byte(input logic [3:0] i);
    case (i)
      4'd0:    seq_byte = 8'hFF;
      4'd1:    seq_byte = 8'h77;
      4'd2:    seq_byte = 8'hB3;
      4'd3:    seq_byte = 8'h51;
      4'd4:    seq_byte = 8'hA8;
      4'd5:    seq_byte = 8'hD4;
      4'd6:    seq_byte = 8'h62;
      4'd7:    seq_byte = 8'h39;
      4'd8:    seq_byte = 8'h9C;
      4'd9:    seq_byte = 8'h46;
      4'd10:   seq_byte = 8'h2B;
      4'd11:   seq_byte = 8'h15;
      4'd12:   seq_byte = 8'h8A;
      4'd13:   seq_byte = 8'hCD;
      default: seq_byte = 8'h00;
    endcase
  endfunction

  // Partial decode mirrors the real GA: only A14 low and A9:A8 clear select the CRTC.
  assign port_hit = (FULL_DECODE != 0) ? (A[15:8] == 8'hBC)
                                       : (~A[14] && (A[9:8] == 2'b00));
  assign unused_addr_bits = ^A[7:0];
  assign old_wr_d = io_WR;
  assign wr_event = io_WR & ~old_wr_q & port_hit & plus_mode;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      old_wr_q       <= 1'b0;
      unlocked_q     <= 1'b0;
      unlock_pulse_q <= 1'b0;
      lock_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      old_wr_q       <= old_wr_d;
      unlocked_q     <= unlocked_d;
      unlock_pulse_q <= unlock_pulse_d;
      lock_pulse_q   <= lock_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!plus_mode) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (wr_event) begin
      case (state_q)
        IDLE: if (D != '0) state_d = WAIT0;
        WAIT0: if (D == '0) begin
          state_d = MATCH;
          idx_d   = '0;
        end
        MATCH: begin
          if (D == seq_byte(idx_q)) begin
            if (idx_q == 4'd13) state_d = FINAL;
            else                idx_d   = idx_q + 4'd1;
          end else if (D == '0) begin
            idx_d = '0;
          end else begin
            state_d = WAIT0;
          end
        end
        FINAL: begin
          if (D == '0) begin
            state_d = MATCH;
            idx_d   = '0;
          end else begin
            state_d = WAIT0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Lock state only moves on the byte consumed in FINAL; strobes fire on real transitions.
  always_comb begin
    unlocked_d = unlocked_q;
    if (!plus_mode)
      unlocked_d = 1'b0;
    else if (wr_event && (state_q == FINAL))
      unlocked_d = (D == UNLOCK_BYTE);
    unlock_pulse_d = unlocked_d & ~unlocked_q;
    lock_pulse_d   = ~unlocked_d & unlocked_q;
  end

  assign asic_unlocked = unlocked_q;
  assign unlock_pulse  = unlock_pulse_q;
  assign lock_pulse    = lock_pulse_q;

`ifdef UNLOCK_DEBUG_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (unlock_pulse_q && (cnt_q != '1))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign dbg_state      = state_q;
  assign dbg_idx        = idx_q;
  assign dbg_unlock_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_amstrad_asic_unlock.sv
// Self-checking bench for amstrad_asic_unlock using a byte-history reference model.
module tb_amstrad_asic_unlock;

  logic        CLK = 1'b0;
  logic        reset;
  logic        plus_mode;
  logic        io_WR;
  logic [15:0] A;
  logic [7:0]  D;
  logic        asic_unlocked;
  logic        unlock_pulse;
  logic        lock_pulse;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  amstrad_asic_unlock #(.FULL_DECODE(0), .UNLOCK_BYTE(8'hEE)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .plus_mode    (plus_mode),
    .io_WR        (io_WR),
    .A            (A),
    .D            (D),
    .asic_unlocked(asic_unlocked),
    .unlock_pulse (unlock_pulse),
    .lock_pulse   (lock_pulse)
  );

  logic [7:0] seq_tab [14] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                               8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

  // Model: remember the last 15 accepted bytes after the first nonzero one.
  // A byte is the deciding byte when those 15 read 00 followed by the 14-byte sequence.
  logic [7:0] hist[$];
  logic [7:0] sq[$];
  bit m_nz, m_unl, m_up, m_lp;

  function automatic bit m_hit(input logic [15:0] a);
    return (a[14] == 1'b0) && (a[9:8] == 2'b00);
  endfunction

  function automatic void m_clear();
    hist.delete();
    m_nz = 1'b0;
  endfunction

  function automatic void m_event(input logic [7:0] b);
    bit fin, nu;
    fin = 1'b0;
    if (hist.size() == 15) begin
      fin = (hist[0] == 8'h00);
      for (int k = 0; k < 14; k++)
        if (hist[k+1] != seq_tab[k]) fin = 1'b0;
    end
    if (fin) begin
      nu    = (b == 8'hEE);
      m_up  = nu & ~m_unl;
      m_lp  = ~nu & m_unl;
      m_unl = nu;
    end
    if (b != 8'h00) m_nz = 1'b1;
    if (m_nz) begin
      hist.push_back(b);
      if (hist.size() > 15) void'(hist.pop_front());
    end
  endfunction

  function automatic void build(input logic [7:0] pre, input logic [7:0] last);
    sq.delete();
    sq.push_back(pre);
    sq.push_back(8'h00);
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    sq.push_back(last);
  endfunction

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return {8'hBC, 8'($urandom)};
      2:       return {8'h3C, 8'($urandom)};
      3:       return {8'hBD, 8'($urandom)};
      4:       return {8'h7F, 8'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return seq_tab[$urandom_range(0, 13)];
      2:       return 8'hEE;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK) io_WR = 1'b0;
    @(negedge CLK);
    A = a; D = d; io_WR = 1'b1;
    @(posedge CLK); #1;
    m_up = 1'b0; m_lp = 1'b0;
    if (m_hit(a)) m_event(d);
  endtask

  task automatic idle_cycle();
    @(negedge CLK) io_WR = 1'b0;
    @(posedge CLK); #1;
    m_up = 1'b0; m_lp = 1'b0;
  endtask

  task automatic drop_plus();
    @(negedge CLK);
    io_WR = 1'b0; plus_mode = 1'b0;
    @(posedge CLK); #1;
    plus_mode = 1'b1;
    m_up = 1'b0; m_lp = m_unl; m_unl = 1'b0;
    m_clear();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    io_WR = 1'b0; reset = 1'b1;
    @(negedge CLK) reset = 1'b0;
    m_clear();
    m_unl = 1'b0; m_up = 1'b0; m_lp = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    reset = 1'b1; plus_mode = 1'b1; io_WR = 1'b0; A = '0; D = '0;
    #1;
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL reset_async got=%b expected=000", got);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset = 1'b0;
    m_clear(); m_unl = 1'b0; m_up = 1'b0; m_lp = 1'b0;
    @(posedge CLK); #1;
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL reset_release got=%b expected=000", got);
    end
  endtask

  task automatic run_sq(input string name, input logic [15:0] a);
    logic [2:0] got, exp;
    foreach (sq[i]) begin
      do_write(a, sq[i]);
      got = {asic_unlocked, unlock_pulse, lock_pulse};
      exp = {m_unl, m_up, m_lp};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL %s[%0d] d=%h got=%b expected=%b", name, i, sq[i], got, exp);
      end
    end
  endtask

  task automatic test_unlock();
    logic [2:0] got;
    build(8'h01, 8'hEE);
    run_sq("unlock_seq", 16'hBC00);
    idle_cycle();
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== {m_unl, 2'b00} || got !== 3'b100) begin
      bad++; $display("FAIL unlock_pulse_width got=%b expected=100", got);
    end
  endtask

  task automatic test_lock();
    logic [2:0] got;
    build(8'h01, 8'hA5);
    run_sq("lock_seq", 16'hBC00);
    idle_cycle();
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL lock_pulse_width got=%b expected=000", got);
    end
  endtask

  task automatic test_resync();
    sq.delete();
    sq.push_back(8'h01); sq.push_back(8'h00);
    for (int k = 0; k < 5; k++) sq.push_back(seq_tab[k]);
    sq.push_back(8'h00);
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    sq.push_back(8'hEE);
    run_sq("resync_seq", 16'hBC00);
    total++;
    if (asic_unlocked !== 1'b1) begin
      bad++; $display("FAIL resync_final got=%b expected=1", asic_unlocked);
    end
  endtask

  task automatic test_ignored();
    logic [2:0] got, exp;
    do_reset();
    build(8'h01, 8'hEE);
    run_sq("port_7f", 16'h7F00);
    sq.delete(); sq.push_back(8'h01);
    run_sq("held_pre", 16'hBC00);
    @(negedge CLK) io_WR = 1'b0;
    @(negedge CLK);
    A = 16'hBC00; D = 8'h00; io_WR = 1'b1;
    @(posedge CLK); #1;
    m_up = 1'b0; m_lp = 1'b0; m_event(8'h00);
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK) D = (k < 14) ? seq_tab[k] : 8'hEE;
      @(posedge CLK); #1;
      got = {asic_unlocked, unlock_pulse, lock_pulse};
      exp = {m_unl, 2'b00};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL held_wr[%0d] got=%b expected=%b", k, got, exp);
      end
    end
    sq.delete();
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    sq.push_back(8'hEE);
    run_sq("held_after", 16'hBC00);
  endtask

  task automatic test_plus_drop();
    logic [2:0] got, exp;
    build(8'h01, 8'hEE);
    run_sq("plus_pre", 16'hBC00);
    drop_plus();
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    exp = {m_unl, m_up, m_lp};
    total++;
    if (got !== exp || got !== 3'b001) begin
      bad++; $display("FAIL plus_drop got=%b expected=%b", got, exp);
    end
    idle_cycle();
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL plus_drop_after got=%b expected=000", got);
    end
    sq.delete(); sq.push_back(8'h00);
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    sq.push_back(8'hEE);
    run_sq("plus_idle", 16'hBC00);
  endtask

  task automatic test_reset_mid();
    logic [2:0] got;
    build(8'h01, 8'hEE);
    run_sq("rst_pre", 16'hBC00);
    sq.delete(); sq.push_back(8'h01); sq.push_back(8'h00);
    for (int k = 0; k < 6; k++) sq.push_back(seq_tab[k]);
    run_sq("rst_mid", 16'hBC00);
    @(negedge CLK); #2;
    io_WR = 1'b0; reset = 1'b1;
    #1;
    got = {asic_unlocked, unlock_pulse, lock_pulse};
    total++;
    if (got !== 3'b000) begin
      bad++; $display("FAIL reset_mid got=%b expected=000", got);
    end
    @(negedge CLK) reset = 1'b0;
    m_clear(); m_unl = 1'b0; m_up = 1'b0; m_lp = 1'b0;
    sq.delete();
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    sq.push_back(8'hEE);
    run_sq("rst_no_pre", 16'hBC00);
  endtask

  task automatic test_decode();
    do_reset();
    sq.delete(); sq.push_back(8'h01); sq.push_back(8'h00);
    foreach (seq_tab[k]) sq.push_back(seq_tab[k]);
    run_sq("dec_pre", 16'hBC00);
    sq.delete(); sq.push_back(8'hEE);
    run_sq("dec_bd", 16'hBD00);
    run_sq("dec_3c", 16'h3C00);
    total++;
    if (asic_unlocked !== 1'b1) begin
      bad++; $display("FAIL decode_3c got=%b expected=1", asic_unlocked);
    end
  endtask

  task automatic test_random();
    logic [2:0]  got, exp;
    logic [15:0] qa[$];
    logic [7:0]  qd[$];
    int unsigned r;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        drop_plus();
        got = {asic_unlocked, unlock_pulse, lock_pulse};
        exp = {m_unl, m_up, m_lp};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL random_plus[%0d] got=%b expected=%b", n, got, exp);
        end
      end else begin
        qa.delete(); qd.delete();
        if (r < 35) begin
          build(8'($urandom_range(1, 255)), ($urandom_range(0, 1) == 1) ? 8'hEE : 8'($urandom));
          if ($urandom_range(0, 3) == 0) sq[$urandom_range(0, 16)] = 8'($urandom);
          foreach (sq[i]) begin
            qa.push_back({8'hBC, 8'($urandom)});
            qd.push_back(sq[i]);
          end
        end else begin
          qa.push_back(pick_addr());
          qd.push_back(pick_data());
        end
        foreach (qa[i]) begin
          do_write(qa[i], qd[i]);
          got = {asic_unlocked, unlock_pulse, lock_pulse};
          exp = {m_unl, m_up, m_lp};
          total++;
          if (got !== exp) begin
            bad++; $display("FAIL random[%0d.%0d] a=%h d=%h got=%b expected=%b",
                            n, i, qa[i], qd[i], got, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lock();
    test_resync();
    test_ignored();
    test_plus_drop();
    test_reset_mid();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
